// File: rtl/relu_maxpool2x2_if.sv
// Sample stream bundle for the ReLU + 2x2 max-pool stage: conv samples in,
// pooled samples and end-of-frame pulse out. No backpressure.
interface relu_maxpool2x2_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  frame_done;

   modport master (
      output data_in, valid_in,
      input  data_out, valid_out, frame_done
   );

   modport slave (
      input  data_in, valid_in,
      output data_out, valid_out, frame_done
   );
endinterface

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 / stride-2 max pooling over one raster-ordered
// binary32 feature map; one pooled sample per completed 2x2 window.
module relu_maxpool2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 112,
   parameter int HEIGHT     = 112
) (
   input logic              clk,
   input logic              rst,
   relu_maxpool2x2_if.slave bus
);
   localparam int HALF  = WIDTH / 2;
   localparam int COL_W = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
   localparam int IDX_W = (HALF   > 1) ? $clog2(HALF)   : 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] relu_val;
   logic [DATA_WIDTH-1:0] pair;
   logic [DATA_WIDTH-1:0] line_rd;
   logic [DATA_WIDTH-1:0] pooled;
   logic [DATA_WIDTH-1:0] linebuf [HALF];
   logic                  at_col_end;
   logic                  at_row_end;

   // Once negatives are clamped to +0.0 every operand is a non-negative float,
   // whose bit patterns order the same way as unsigned integers.
   assign relu_val   = bus.data_in[DATA_WIDTH-1] ? '0 : bus.data_in;
   assign pair       = (hold > relu_val) ? hold : relu_val;
   assign idx        = IDX_W'(col >> 1);
   assign line_rd    = linebuf[idx];
   assign pooled     = (line_rd > pair) ? line_rd : pair;
   assign at_col_end = (col == LAST_COL);
   assign at_row_end = (row == LAST_ROW);

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col        <= '0;
         row        <= '0;
         hold       <= '0;
         bus.data_out   <= '0;
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.valid_in) begin
            if (at_col_end) begin
               col <= '0;
               row <= at_row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end

            if (!col[0]) begin
               hold <= relu_val;
            end else if (row[0]) begin
               bus.data_out   <= pooled;
               bus.valid_out  <= 1'b1;
               bus.frame_done <= at_row_end && at_col_end;
            end
         end
      end
   end

   // NOTE: the line buffer has no reset; every entry is written on an even row
   // before the following odd row reads it, so its power-up contents never matter.
   always_ff @(posedge clk) begin
      if (bus.valid_in && col[0] && !row[0]) begin
         linebuf[idx] <= pair;
      end
   end
endmodule
